// File: rtl/btn_event_arbiter.sv
// Multi-channel pushbutton event controller: synchronize, debounce and latch rising edges,
// then offer one pending channel ID at a time over valid/ready in round-robin order.
module btn_event_arbiter #(
  parameter int N          = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int DEBOUNCE   = 4,
  parameter int IDW        = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   async_in,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                state, state_next;
  logic [SYNC_DEPTH-1:0] chain [N];
  logic [CW-1:0]         cnt [N];
  logic [N-1:0]          sync, stable, rise, clr;
  logic [IDW-1:0]        ptr, ptr_next, id_next, idx;
  logic                  found, handshake;

  assign evt_valid = (state == OFFER);
  assign handshake = evt_valid && evt_ready;

  // NOTE: the synchronizer chain and debounce counters are small per-channel registers, not a
  // RAM, so they take the synchronous reset like every other flop here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) chain[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        chain[i][0] <= async_in[i];
        for (int s = 1; s < SYNC_DEPTH; s++) chain[i][s] <= chain[i][s-1];
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default before any branch, so no latches.
  always_comb begin
    sync = '0;
    rise = '0;
    clr  = '0;
    for (int i = 0; i < N; i++) begin
      sync[i] = chain[i][SYNC_DEPTH-1];
      rise[i] = sync[i] && !stable[i] && (cnt[i] == CNT_LAST);
      clr[i]  = handshake && (evt_id == IDW'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A rise on the channel being handed off in this same cycle re-arms it instead of overflowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~clr) | rise;
      overflow <= overflow | (rise & pending & ~clr);
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    id_next    = evt_id;
    found      = 1'b0;
    idx        = '0;
    case (state)
      IDLE: begin
        for (int k = 0; k < N; k++) begin
          idx = IDW'((int'(ptr) + k) % N);
          if (!found && pending[idx]) begin
            found   = 1'b1;
            id_next = idx;
          end
        end
        if (found) state_next = OFFER;
      end
      OFFER: begin
        if (evt_ready) begin
          state_next = IDLE;
          ptr_next   = IDW'((int'(evt_id) + 1) % N);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      evt_id <= '0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      evt_id <= id_next;
    end
  end

endmodule
